control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Microcode sequencer for the 8-bit bus CPU. It steps through fetch and execute T-states and decodes the 4-bit opcode from the instruction register. Using the carry and zero flags, it drives every module control strobe: program counter inc/jump/out, MAR, RAM, IR, A, B, ALU, output and flags registers. It sits directly upstream of the program counter and the other bus modules. It is the only source of their control inputs.

Parameters:
NUM_STEPS, 5, T-states per instruction when early end is disabled (legal 5..8); step counter width is 3 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  4  upper nibble of instruction register
carry_flag  input  1  registered carry flag
zero_flag  input  1  registered zero flag
step  output  3  current T-state (debug/LED)
hlt  output  1  halt; gates system clock externally
mar_in  output  1  MAR loads from bus
ram_in  output  1  RAM writes from bus
ram_out  output  1  RAM drives bus
ir_in  output  1  IR loads from bus
ir_out  output  1  IR drives low nibble onto bus
a_in  output  1  A register loads
a_out  output  1  A register drives bus
b_in  output  1  B register loads
alu_out  output  1  ALU drives bus
alu_sub  output  1  ALU subtract select
flags_in  output  1  flags register loads
out_in  output  1  output register loads
pc_inc  output  1  program counter increment
pc_jump  output  1  program counter loads from bus
pc_out  output  1  program counter drives bus

Behaviour:
- State: step counter (3 bits) and halted bit. On a clock edge with rst=1: step=0, halted=0.
- Control outputs are combinational decode of step, opcode, flags and halted. While rst=1, all control outputs are 0 and step reads 0.
- Step advances by +1 per clock. After step NUM_STEPS-1 it wraps to 0.
- Fetch, all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
- Execute (unlisted steps drive nothing):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 ir_out+mar_in; T3 ram_out+a_in.
  - 0x2 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+flags_in.
  - 0x3 SUB: as ADD, plus alu_sub=1 on T4.
  - 0x4 STA: T2 ir_out+mar_in; T3 a_out+ram_in.
  - 0x5 LDI: T2 ir_out+a_in.
  - 0x6 JMP: T2 ir_out+pc_jump.
  - 0x7 JC: T2 ir_out+pc_jump only if carry_flag=1; otherwise none.
  - 0x8 JZ: T2 ir_out+pc_jump only if zero_flag=1; otherwise none.
  - 0xE OUT: T2 a_out+out_in.
  - 0xF HLT: T2 hlt.
  - 0x9-0xD: NOP.
- HLT: at the edge ending HLT T2, halted is set. While halted: step frozen at 2, hlt=1, all other controls 0. Only rst clears halted.
- Invariants in every cycle:
  - At most one of pc_out, ram_out, ir_out, a_out, alu_out is high.
  - pc_inc and pc_jump are never both high.
- Flags are sampled combinationally at T2 of JC/JZ. A flag change at any other step has no effect.
- Reset mid-instruction: the instruction is abandoned and the next cycle is T0 fetch. Partial effects already clocked are not undone.

Optional Feature:
SEQ_EARLY_END_EN:
- Defined: step returns to 0 on the edge ending the instruction's last step. Last step is T2 for NOP/LDI/JMP/JC/JZ/OUT/undefined opcodes, T3 for LDA/STA, T4 for ADD/SUB. Instruction lengths become 3/4/5 cycles. HLT behaviour is unchanged.
- Undefined: every instruction takes NUM_STEPS cycles, with trailing steps idle.

Test Plan:
- Reset then free-run with opcode=0x0: step sequence 0,1,2,3,4,0. T0 shows pc_out=mar_in=1; T1 shows ram_out=ir_in=pc_inc=1; T2-T4 all controls 0.
- opcode=0x2 then 0x3: T4 shows alu_out=a_in=flags_in=1, with alu_sub=0 for ADD and 1 for SUB; T3 shows ram_out=b_in=1.
- opcode=0x7 at T2: with carry_flag=1, ir_out=pc_jump=1; with carry_flag=0, all controls 0. Same check for 0x8 with zero_flag.
- opcode=0xF: after T2, hlt stays 1 and step stays 2 for 20 cycles. Assert rst for 1 cycle: hlt=0, and next cycle is T0 with pc_out=1.
- rst asserted at T3 of LDA: all controls 0 during rst; next cycle step=0 with fetch signals.
- With SEQ_EARLY_END_EN, program LDI, LDA, ADD: step traces 0,1,2 | 0,1,2,3 | 0,1,2,3,4. Bus-driver and inc/jump exclusivity asserted throughout all tests.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcode sequencer: steps fetch/execute T-states and decodes the opcode into bus control strobes.
// Build option: define SEQ_EARLY_END_EN to end each instruction right after its last active step.
module control_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       pc_out
);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] step_reg, step_next;
  logic       halted_reg, halted_next;
  logic [2:0] last_step;
  logic       hlt_decode;

  assign hlt_decode = (step_reg == 3'd2) && (opcode == OP_HLT);

`ifdef SEQ_EARLY_END_EN
  always_comb begin
    last_step = 3'd2;
    case (opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  end
`else
  assign last_step = 3'(NUM_STEPS - 1);
`endif

  always_comb begin
    step_next   = step_reg;
    halted_next = halted_reg;
    if (halted_reg) begin
      step_next = step_reg;
    end else if (hlt_decode) begin
      // Freeze on T2 so the debug step display shows where the halt occurred.
      halted_next = 1'b1;
    end else if (step_reg >= last_step) begin
      step_next = 3'd0;
    end else begin
      step_next = step_reg + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_reg   <= 3'd0;
      halted_reg <= 1'b0;
    end else begin
      step_reg   <= step_next;
      halted_reg <= halted_next;
    end
  end

  assign step = rst ? 3'd0 : step_reg;

  always_comb begin
    hlt      = 1'b0;
    mar_in   = 1'b0;
    ram_in   = 1'b0;
    ram_out  = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    flags_in = 1'b0;
    out_in   = 1'b0;
    pc_inc   = 1'b0;
    pc_jump  = 1'b0;
    pc_out   = 1'b0;
    if (!rst) begin
      if (halted_reg) begin
        hlt = 1'b1;
      end else begin
        case (step_reg)
          3'd0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
          end
          3'd1: begin
            ram_out = 1'b1;
            ir_in   = 1'b1;
            pc_inc  = 1'b1;
          end
          3'd2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                ir_out = 1'b1;
                mar_in = 1'b1;
              end
              OP_LDI: begin
                ir_out = 1'b1;
                a_in   = 1'b1;
              end
              OP_JMP: begin
                ir_out  = 1'b1;
                pc_jump = 1'b1;
              end
              OP_JC: begin
                ir_out  = carry_flag;
                pc_jump = carry_flag;
              end
              OP_JZ: begin
                ir_out  = zero_flag;
                pc_jump = zero_flag;
              end
              OP_OUT: begin
                a_out  = 1'b1;
                out_in = 1'b1;
              end
              OP_HLT: hlt = 1'b1;
              default: ;
            endcase
          end
          3'd3: begin
            case (opcode)
              OP_LDA: begin
                ram_out = 1'b1;
                a_in    = 1'b1;
              end
              OP_ADD, OP_SUB: begin
                ram_out = 1'b1;
                b_in    = 1'b1;
              end
              OP_STA: begin
                a_out  = 1'b1;
                ram_in = 1'b1;
              end
              default: ;
            endcase
          end
          3'd4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
              alu_out  = 1'b1;
              a_in     = 1'b1;
              flags_in = 1'b1;
              alu_sub  = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_control_sequencer;

  localparam logic [15:0] HL = 16'h8000;
  localparam logic [15:0] MI = 16'h4000;
  localparam logic [15:0] RI = 16'h2000;
  localparam logic [15:0] RO = 16'h1000;
  localparam logic [15:0] II = 16'h0800;
  localparam logic [15:0] IO = 16'h0400;
  localparam logic [15:0] AI = 16'h0200;
  localparam logic [15:0] AO = 16'h0100;
  localparam logic [15:0] BI = 16'h0080;
  localparam logic [15:0] EO = 16'h0040;
  localparam logic [15:0] SU = 16'h0020;
  localparam logic [15:0] FI = 16'h0010;
  localparam logic [15:0] OI = 16'h0008;
  localparam logic [15:0] CE = 16'h0004;
  localparam logic [15:0] J  = 16'h0002;
  localparam logic [15:0] CO = 16'h0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic [2:0] step;
  logic hlt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in;
  logic alu_out, alu_sub, flags_in, out_in, pc_inc, pc_jump, pc_out;

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .step(step), .hlt(hlt), .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
    .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in), .a_out(a_out), .b_in(b_in),
    .alu_out(alu_out), .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in),
    .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  step;
    logic [15:0] ctrl;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] ctrl_vec;
  assign ctrl_vec = {hlt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in,
                     alu_out, alu_sub, flags_in, out_in, pc_inc, pc_jump, pc_out};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      n_checks++;
      if (step !== cur.step || ctrl_vec !== cur.ctrl) begin
        n_fail++;
        $display("FAIL %s: got step=%0d ctrl=%h, expected step=%0d ctrl=%h",
                 cur.tag, step, ctrl_vec, cur.step, cur.ctrl);
      end else begin
        $display("ok   %s: step=%0d ctrl=%h", cur.tag, step, ctrl_vec);
      end
      n_checks++;
      if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1 || (pc_inc && pc_jump)) begin
        n_fail++;
        $display("FAIL %s_exclusive: drivers=%b inc_jump=%b, required at most one driver and not both",
                 cur.tag, {pc_out, ram_out, ir_out, a_out, alu_out}, {pc_inc, pc_jump});
      end
    end
  end

  task automatic cyc(input logic [3:0] op, input logic c, input logic z, input logic r,
                     input logic [2:0] es, input logic [15:0] ec, input string tag);
    exp_t e;
    opcode = op;
    carry_flag = c;
    zero_flag = z;
    rst = r;
    e.step = es;
    e.ctrl = ec;
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input logic c, input logic z, input string tag);
    cyc(op, c, z, 1'b0, 3'd0, CO | MI, {tag, "_t0"});
    cyc(op, c, z, 1'b0, 3'd1, RO | II | CE, {tag, "_t1"});
  endtask

  // Idle trailing steps exist only when every instruction runs the full five T-states.
  task automatic pad(input logic [3:0] op, input int from, input logic c, input logic z, input string tag);
`ifndef SEQ_EARLY_END_EN
    for (int s = from; s < 5; s++) cyc(op, c, z, 1'b0, 3'(s), 16'h0, {tag, "_idle"});
`else
    if (from < 0) $display("unused %s %0h %b %b", tag, op, c, z);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    cyc(4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0, "reset");

    fetch(4'h0, 1'b1, 1'b1, "nop");
    cyc(4'h0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0, "nop_t2");
    pad(4'h0, 3, 1'b1, 1'b1, "nop");

    fetch(4'h5, 1'b0, 1'b0, "ldi");
    cyc(4'h5, 1'b0, 1'b0, 1'b0, 3'd2, IO | AI, "ldi_t2");
    pad(4'h5, 3, 1'b0, 1'b0, "ldi");

    fetch(4'h1, 1'b0, 1'b0, "lda");
    cyc(4'h1, 1'b0, 1'b0, 1'b0, 3'd2, IO | MI, "lda_t2");
    cyc(4'h1, 1'b0, 1'b0, 1'b0, 3'd3, RO | AI, "lda_t3");
    pad(4'h1, 4, 1'b0, 1'b0, "lda");

    fetch(4'h2, 1'b0, 1'b0, "add");
    cyc(4'h2, 1'b0, 1'b0, 1'b0, 3'd2, IO | MI, "add_t2");
    cyc(4'h2, 1'b0, 1'b0, 1'b0, 3'd3, RO | BI, "add_t3");
    cyc(4'h2, 1'b0, 1'b0, 1'b0, 3'd4, EO | AI | FI, "add_t4");

    fetch(4'h3, 1'b1, 1'b0, "sub");
    cyc(4'h3, 1'b1, 1'b0, 1'b0, 3'd2, IO | MI, "sub_t2");
    cyc(4'h3, 1'b1, 1'b0, 1'b0, 3'd3, RO | BI, "sub_t3");
    cyc(4'h3, 1'b1, 1'b0, 1'b0, 3'd4, EO | AI | FI | SU, "sub_t4");

    fetch(4'h4, 1'b0, 1'b0, "sta");
    cyc(4'h4, 1'b0, 1'b0, 1'b0, 3'd2, IO | MI, "sta_t2");
    cyc(4'h4, 1'b0, 1'b0, 1'b0, 3'd3, AO | RI, "sta_t3");
    pad(4'h4, 4, 1'b0, 1'b0, "sta");

    fetch(4'h6, 1'b0, 1'b0, "jmp");
    cyc(4'h6, 1'b0, 1'b0, 1'b0, 3'd2, IO | J, "jmp_t2");
    pad(4'h6, 3, 1'b0, 1'b0, "jmp");

    fetch(4'h7, 1'b0, 1'b0, "jc_taken");
    cyc(4'h7, 1'b1, 1'b0, 1'b0, 3'd2, IO | J, "jc_taken_t2");
    pad(4'h7, 3, 1'b0, 1'b0, "jc_taken");

    fetch(4'h7, 1'b1, 1'b1, "jc_not");
    cyc(4'h7, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0, "jc_not_t2");
    pad(4'h7, 3, 1'b1, 1'b1, "jc_not");

    fetch(4'h8, 1'b1, 1'b0, "jz_taken");
    cyc(4'h8, 1'b0, 1'b1, 1'b0, 3'd2, IO | J, "jz_taken_t2");
    pad(4'h8, 3, 1'b1, 1'b0, "jz_taken");

    fetch(4'h8, 1'b1, 1'b1, "jz_not");
    cyc(4'h8, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0, "jz_not_t2");
    pad(4'h8, 3, 1'b1, 1'b1, "jz_not");

    fetch(4'hE, 1'b0, 1'b0, "out");
    cyc(4'hE, 1'b0, 1'b0, 1'b0, 3'd2, AO | OI, "out_t2");
    pad(4'hE, 3, 1'b0, 1'b0, "out");

    fetch(4'hB, 1'b1, 1'b1, "undef");
    cyc(4'hB, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0, "undef_t2");
    pad(4'hB, 3, 1'b1, 1'b1, "undef");

    fetch(4'h1, 1'b0, 1'b0, "lda_abort");
    cyc(4'h1, 1'b0, 1'b0, 1'b0, 3'd2, IO | MI, "lda_abort_t2");
    cyc(4'h1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0, "lda_abort_rst");
    fetch(4'h1, 1'b0, 1'b0, "lda_after_rst");
    cyc(4'h1, 1'b0, 1'b0, 1'b0, 3'd2, IO | MI, "lda_after_rst_t2");
    cyc(4'h1, 1'b0, 1'b0, 1'b0, 3'd3, RO | AI, "lda_after_rst_t3");
    pad(4'h1, 4, 1'b0, 1'b0, "lda_after_rst");

    fetch(4'hF, 1'b0, 1'b0, "hlt");
    cyc(4'hF, 1'b0, 1'b0, 1'b0, 3'd2, HL, "hlt_t2");
    for (int i = 0; i < 20; i++) cyc(4'hF, i[0], i[1], 1'b0, 3'd2, HL, "halted");
    cyc(4'hF, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0, "halt_rst");
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 3'd0, CO | MI, "post_halt_t0");
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 3'd1, RO | II | CE, "post_halt_t1");

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
